// File: rtl/hram_pkg.sv
// Shared types and constants for the HyperRAM command sequencer and its write FIFO.
package hram_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_RUN       = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDERRUN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/hram_wr_fifo.sv
// First-word-fall-through write FIFO: head is visible combinationally (0 when empty), 1-cycle push-to-head.
// Push is ignored when full and pop is ignored when empty; flush empties it on the next edge.
module hram_wr_fifo
  import hram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/hyperram_cmd_sequencer.sv
// One-at-a-time HyperRAM command stage: read cs 1 cycle after accept, write cs 2 cycles; read data 1-cycle lag.
// cmd_ready only in IDLE, wd_ready = FIFO not full, no rd backpressure. `HRAM_SEQ_TIMEOUT_EN adds a busy-wait timeout.
module hyperram_cmd_sequencer
  import hram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic        cmd_reg,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_num_words,
  input  logic [2:0]  cmd_latency,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        ctrl_cs,
  output logic        ctrl_rd_sel,
  output logic        ctrl_wr_sel,
  output logic        ctrl_mem_sel,
  output logic        ctrl_reg_sel,
  output logic [7:0]  ctrl_num_words,
  output logic [2:0]  ctrl_latency,
  output logic [31:0] ctrl_addr_in,
  output logic [31:0] ctrl_wr_data_in,
  input  logic        ctrl_wr_data_next,
  input  logic [31:0] ctrl_rd_data_out,
  input  logic        ctrl_rd_data_valid,
  input  logic        ctrl_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  logic               cmd_ready_q, cs_q, rd_sel_q, wr_sel_q, mem_sel_q, reg_sel_q;
  logic [7:0]         nw_q, rx_cnt_q;
  logic [2:0]         lat_q;
  logic [31:0]        addr_q, rd_data_q;
  logic               rd_valid_q, done_q, err_q;
  logic [1:0]         err_code_q;
`ifdef HRAM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  logic [TO_W-1:0]    to_cnt_q;
`endif

  logic               fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [WORD_W-1:0]  fifo_head;
  logic               underrun, rd_take, fill_ok;

  assign fifo_pop   = (state_q == ST_RUN) && wr_sel_q && ctrl_wr_data_next;
  assign underrun   = fifo_pop && fifo_empty;
  assign fifo_flush = (state_q == ST_FINISH) && wr_sel_q;
  assign rd_take    = (state_q == ST_RUN) && rd_sel_q && ctrl_rd_data_valid && (rx_cnt_q < nw_q);
  assign fill_ok    = (32'(fifo_cnt) >= 32'(nw_q)) || fifo_full;

  hram_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_wr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (fifo_flush),
    .push_i     (wd_valid),
    .push_dat_i (wd_data),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      cs_q        <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_sel_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      reg_sel_q   <= 1'b0;
      nw_q        <= '0;
      lat_q       <= '0;
      addr_q      <= '0;
      rx_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef HRAM_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      cs_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            rd_sel_q    <= !cmd_wr;
            wr_sel_q    <= cmd_wr;
            mem_sel_q   <= !cmd_reg;
            reg_sel_q   <= cmd_reg;
            nw_q        <= cmd_reg ? 8'd1 : cmd_num_words;
            lat_q       <= cmd_latency;
            addr_q      <= cmd_addr;
            rx_cnt_q    <= '0;
            if (!cmd_reg && cmd_num_words == 8'd0) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else if (cmd_wr) begin
              state_q <= ST_FILL;
            end else begin
              state_q <= ST_ISSUE;
              cs_q    <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (fill_ok) begin
            state_q <= ST_ISSUE;
            cs_q    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_BUSY;
`ifdef HRAM_SEQ_TIMEOUT_EN
          // Counts from the cs cycle so the error lands BUSY_TIMEOUT cycles after cs.
          to_cnt_q <= TO_W'(1);
`endif
        end
        ST_WAIT_BUSY: begin
          if (ctrl_busy) begin
            state_q <= ST_RUN;
`ifdef HRAM_SEQ_TIMEOUT_EN
          end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
            state_q    <= ST_FINISH;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            done_q     <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
          end
        end
        ST_RUN: begin
          if (underrun) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_UNDERRUN;
          end
          if (rd_take) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= ctrl_rd_data_out;
            rx_cnt_q   <= rx_cnt_q + 8'd1;
          end
          if (!ctrl_busy) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign wd_ready        = !fifo_full;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign done            = done_q;
  assign err             = err_q;
  assign err_code        = err_code_q;
  assign ctrl_cs         = cs_q;
  assign ctrl_rd_sel     = rd_sel_q;
  assign ctrl_wr_sel     = wr_sel_q;
  assign ctrl_mem_sel    = mem_sel_q;
  assign ctrl_reg_sel    = reg_sel_q;
  assign ctrl_num_words  = nw_q;
  assign ctrl_latency    = lat_q;
  assign ctrl_addr_in    = addr_q;
  assign ctrl_wr_data_in = fifo_head;

endmodule

// File: tb/tb_hyperram_cmd_sequencer.sv
// Directed bench for hyperram_cmd_sequencer: host and controller sides are driven by hand-timed tasks.
module tb_hyperram_cmd_sequencer;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr, cmd_reg;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_num_words;
  logic [2:0]  cmd_latency;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, err;
  logic [1:0]  err_code;
  logic        ctrl_cs, ctrl_rd_sel, ctrl_wr_sel, ctrl_mem_sel, ctrl_reg_sel;
  logic [7:0]  ctrl_num_words;
  logic [2:0]  ctrl_latency;
  logic [31:0] ctrl_addr_in, ctrl_wr_data_in;
  logic        ctrl_wr_data_next, ctrl_rd_data_valid, ctrl_busy;
  logic [31:0] ctrl_rd_data_out;

  int n_chk = 0, n_err = 0;
  int cs_cnt = 0, done_cnt = 0, err_cnt = 0, rdv_cnt = 0;
  logic [31:0] heads [32];
  logic        errs  [32];

  hyperram_cmd_sequencer #(.FIFO_DEPTH(16), .BUSY_TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_reg(cmd_reg),
    .cmd_addr(cmd_addr), .cmd_num_words(cmd_num_words), .cmd_latency(cmd_latency),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .err_code(err_code),
    .ctrl_cs(ctrl_cs), .ctrl_rd_sel(ctrl_rd_sel), .ctrl_wr_sel(ctrl_wr_sel),
    .ctrl_mem_sel(ctrl_mem_sel), .ctrl_reg_sel(ctrl_reg_sel),
    .ctrl_num_words(ctrl_num_words), .ctrl_latency(ctrl_latency),
    .ctrl_addr_in(ctrl_addr_in), .ctrl_wr_data_in(ctrl_wr_data_in),
    .ctrl_wr_data_next(ctrl_wr_data_next), .ctrl_rd_data_out(ctrl_rd_data_out),
    .ctrl_rd_data_valid(ctrl_rd_data_valid), .ctrl_busy(ctrl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ctrl_cs)  cs_cnt++;
    if (done)     done_cnt++;
    if (err)      err_cnt++;
    if (rd_valid) rdv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wd_valid = 1'b1;
    wd_data  = d;
    tick();
    wd_valid = 1'b0;
  endtask

  // Returns just after the accepting edge, i.e. inside cycle N+1.
  task automatic send_cmd(input logic wr, input logic rg, input logic [31:0] a,
                          input logic [7:0] nw, input logic [2:0] lat);
    check("cmd_ready_before_send", cmd_ready, 1);
    cmd_wr = wr; cmd_reg = rg; cmd_addr = a; cmd_num_words = nw; cmd_latency = lat;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin found = 1; break; end
    end
    check(tag, found, 1);
    tick();
  endtask

  // Called at the negedge of the cs cycle: raise busy, pop n words, drop busy.
  task automatic run_wr(input int n, input string tag);
    tick();
    ctrl_busy = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      ctrl_wr_data_next = 1'b1;
      @(negedge clk);
      heads[i] = ctrl_wr_data_in;
      if (i > 0) errs[i-1] = err;
      tick();
    end
    ctrl_wr_data_next = 1'b0;
    @(negedge clk);
    errs[n-1] = err;
    ctrl_busy = 1'b0;
    wait_done(tag, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, d0, e0, r0, first_err, first_done;
    logic [31:0] rvals [4];
    rvals[0] = 32'h11; rvals[1] = 32'h22; rvals[2] = 32'h33; rvals[3] = 32'h44;
    rst_n = 1'b0; cmd_valid = 0; cmd_wr = 0; cmd_reg = 0; cmd_addr = 0; cmd_num_words = 0;
    cmd_latency = 0; wd_valid = 0; wd_data = 0; ctrl_wr_data_next = 0; ctrl_rd_data_out = 0;
    ctrl_rd_data_valid = 0; ctrl_busy = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wd_ready", wd_ready, 1);
    check("rst_cs", ctrl_cs, 0);
    check("rst_done", done, 0);
    check("rst_err_code", err_code, 0);
    check("rst_num_words", ctrl_num_words, 0);
    check("rst_wr_data_in", ctrl_wr_data_in, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Memory write, 4 words; a fifth pushed word must be discarded at the end
    for (int i = 0; i < 5; i++) push(32'hA0 + i);
    c0 = cs_cnt; d0 = done_cnt; e0 = err_cnt;
    send_cmd(1, 0, 32'h100, 8'd4, 3'd1);
    @(negedge clk);
    check("wr4_fill_cs_low", ctrl_cs, 0);
    @(negedge clk);
    check("wr4_cs_n_plus_2", ctrl_cs, 1);
    check("wr4_addr", ctrl_addr_in, 32'h100);
    check("wr4_sel", {ctrl_wr_sel, ctrl_rd_sel, ctrl_mem_sel, ctrl_reg_sel}, 4'b1010);
    check("wr4_num_words", ctrl_num_words, 4);
    run_wr(4, "wr4_done");
    for (int i = 0; i < 4; i++) check($sformatf("wr4_pop%0d", i), heads[i], 32'hA0 + i);
    check("wr4_cs_count", cs_cnt - c0, 1);
    check("wr4_done_count", done_cnt - d0, 1);
    check("wr4_no_err", err_cnt - e0, 0);
    @(negedge clk);
    check("wr4_fifo_flushed", ctrl_wr_data_in, 0);
    check("wr4_cmd_ready_back", cmd_ready, 1);
    tick();

    // Memory read, 3 words; the fourth returned word is dropped
    r0 = rdv_cnt;
    send_cmd(0, 0, 32'h200, 8'd3, 3'd2);
    @(negedge clk);
    check("rd3_cs_n_plus_1", ctrl_cs, 1);
    check("rd3_rd_sel", ctrl_rd_sel, 1);
    check("rd3_latency", ctrl_latency, 2);
    tick();
    ctrl_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ctrl_rd_data_valid = 1'b1;
      ctrl_rd_data_out   = rvals[i];
      tick();
      ctrl_rd_data_valid = 1'b0;
      @(negedge clk);
      check($sformatf("rd3_valid%0d", i), rd_valid, (i < 3) ? 1 : 0);
      check($sformatf("rd3_data%0d", i), rd_data, (i < 3) ? rvals[i] : 32'h33);
    end
    ctrl_busy = 1'b0;
    wait_done("rd3_done", 8);
    check("rd3_valid_count", rdv_cnt - r0, 3);

    // Register write: word count forced to 1
    push(32'h55);
    send_cmd(1, 1, 32'h8, 8'd5, 3'd0);
    @(negedge clk);
    check("reg_num_words", ctrl_num_words, 1);
    check("reg_reg_sel", ctrl_reg_sel, 1);
    check("reg_mem_sel", ctrl_mem_sel, 0);
    @(negedge clk);
    check("reg_cs", ctrl_cs, 1);
    run_wr(1, "reg_done");
    check("reg_pop0", heads[0], 32'h55);

    // Zero-length command
    c0 = cs_cnt;
    send_cmd(0, 0, 32'h0, 8'd0, 3'd0);
    @(negedge clk);
    check("zero_done_next_cycle", done, 1);
    tick();
    @(negedge clk);
    check("zero_cmd_ready", cmd_ready, 1);
    check("zero_no_cs", cs_cnt - c0, 0);
    tick();

    // 20-word write with only 16 pushed: starts on full, underruns on pop 17
    for (int i = 0; i < 16; i++) push(32'hB0 + i);
    @(negedge clk);
    check("ur_wd_ready_full", wd_ready, 0);
    e0 = err_cnt;
    send_cmd(1, 0, 32'h300, 8'd20, 3'd1);
    @(negedge clk);
    @(negedge clk);
    check("ur_cs_on_full", ctrl_cs, 1);
    run_wr(20, "ur_done");
    check("ur_pop16_data", heads[15], 32'hBF);
    check("ur_pop16_no_err", errs[15], 0);
    check("ur_pop17_data_zero", heads[16], 0);
    check("ur_pop17_err", errs[16], 1);
    check("ur_err_code", err_code, 2'b01);
    check("ur_err_count", err_cnt - e0, 4);

`ifdef HRAM_SEQ_TIMEOUT_EN
    // Busy never rises: timeout error 32 cycles after cs, then done
    d0 = done_cnt;
    first_err = -1; first_done = -1;
    send_cmd(0, 0, 32'h400, 8'd1, 3'd0);
    @(negedge clk);
    check("to_cs", ctrl_cs, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err && first_err < 0) first_err = k;
      if (done && first_done < 0) first_done = k;
    end
    check("to_err_cycle", first_err, 32);
    check("to_err_code", err_code, 2'b10);
    check("to_done_after", (first_done >= 32 && first_done <= 33) ? 1 : 0, 1);
    check("to_done_count", done_cnt - d0, 1);
    tick();
`else
    first_err = 0; first_done = 0;
`endif

    // Reset during ctrl_cs: cs drops without a clock edge
    send_cmd(0, 0, 32'h600, 8'd1, 3'd0);
    #1;
    check("arst_cs_high", ctrl_cs, 1);
    rst_n = 1'b0;
    #1;
    check("arst_cs_async_low", ctrl_cs, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Reset mid-RUN of a write
    push(32'hC0); push(32'hC1);
    send_cmd(1, 0, 32'h500, 8'd2, 3'd3);
    @(negedge clk);
    @(negedge clk);
    check("mr_cs", ctrl_cs, 1);
    tick();
    ctrl_busy = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    d0 = done_cnt;
    check("mr_cmd_ready", cmd_ready, 1);
    check("mr_wd_ready", wd_ready, 1);
    check("mr_done", done, 0);
    check("mr_err_code", err_code, 0);
    check("mr_wr_sel", ctrl_wr_sel, 0);
    check("mr_num_words", ctrl_num_words, 0);
    check("mr_addr", ctrl_addr_in, 0);
    check("mr_fifo_flushed", ctrl_wr_data_in, 0);
    ctrl_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_idle_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hyperram_cmd_sequencer.md
# hyperram_cmd_sequencer

Command sequencer that sits directly upstream of `hyperram_controller` and drives its `ctrl_*` driver interface. It accepts one transaction at a time from a host-side valid/ready command port, buffers write data in a small first-word-fall-through FIFO, and pulses `ctrl_cs` with stable qualifiers. It then feeds write words on `ctrl_wr_data_next`, returns read words to the host, and reports completion. This replaces ad-hoc register-poked sequencing in the diagnostic wrapper with a reusable handshake stage.

## Interface
- `FIFO_DEPTH`, 16: write FIFO depth in 32-bit words; power of two, 2..256.
- `BUSY_TIMEOUT`, 32: cycles allowed from `ctrl_cs` pulse to `ctrl_busy` rising.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; transfer when both are high.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_reg` in 1: 1 = register space, 0 = memory space.
- `cmd_addr` in 32: target address.
- `cmd_num_words` in 8: word count.
- `cmd_latency` in 3: latency code, passed through.
- `wd_valid` in 1 / `wd_ready` out 1 / `wd_data` in 32: write-data push into the FIFO.
- `rd_valid` out 1 / `rd_data` out 32: read-data output; no backpressure.
- `done` out 1: one-cycle pulse at transaction end.
- `err` out 1: one-cycle pulse on underrun or timeout.
- `err_code` out 2: 01 = underrun, 10 = timeout; holds until the next `err`.
- `ctrl_cs`, `ctrl_rd_sel`, `ctrl_wr_sel`, `ctrl_mem_sel`, `ctrl_reg_sel` out 1 each.
- `ctrl_num_words` out 8, `ctrl_latency` out 3, `ctrl_addr_in` out 32, `ctrl_wr_data_in` out 32.
- `ctrl_wr_data_next` in 1, `ctrl_rd_data_out` in 32, `ctrl_rd_data_valid` in 1, `ctrl_busy` in 1.

## Operation
- **States:** IDLE, FILL, ISSUE, WAIT_BUSY, RUN, FINISH.
- **IDLE:**
  - `cmd_ready` = 1.
  - On a handshake, latch all `cmd_*` fields into the `ctrl_*` qualifier registers. The qualifiers stay stable until FINISH.
  - `cmd_reg` = 1 forces the latched word count to 1.
  - Latched word count 0 goes straight to FINISH: no `ctrl_cs`, `done` pulses.
  - Otherwise write goes to FILL and read goes to ISSUE.
- **FILL:** leave for ISSUE when FIFO count ≥ word count, or when the FIFO is full.
- **ISSUE:** `ctrl_cs` = 1 for exactly one cycle, then WAIT_BUSY.
- **WAIT_BUSY:** enter RUN on `ctrl_busy` = 1.
- **RUN:**
  - When `ctrl_busy` falls, go to FINISH.
  - Write feed: `ctrl_wr_data_in` is the FIFO head, combinational. Each `ctrl_wr_data_next` cycle pops one word.
  - Pop while empty: drive 0, pulse `err` with code 01, stay in RUN.
  - Read return: each `ctrl_rd_data_valid` cycle captures `ctrl_rd_data_out` into `rd_data` and sets `rd_valid` for one cycle, while the received-word count < word count. Excess words are dropped silently.
- **FINISH:**
  - Pulse `done` and return to IDLE.
  - Write: discard any FIFO words beyond the popped count.
- **FIFO push:**
  - `wd_ready` = !full, in every state.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. The count is one bit wider than the pointers.

## Timing
- Command accepted at edge N:
  - Read: `ctrl_cs` high in cycle N+1.
  - Write, FIFO already sufficient: `ctrl_cs` high in cycle N+2, one FILL cycle.
- `rd_valid`/`rd_data` lag `ctrl_rd_data_valid` by exactly 1 cycle.
- `done` is asserted the cycle after `ctrl_busy` is sampled low in RUN. `cmd_ready` returns high the cycle after `done`.
- **Reset values:**
  - All outputs 0, except `wd_ready` = 1 and `cmd_ready` = 1.
  - FIFO empty, FSM in IDLE, `err_code` = 00.
- **Reset mid-transaction:** immediate abort to IDLE, FIFO flushed, `ctrl_cs` deasserted asynchronously. No `done` is produced.

## Configuration
- `HRAM_SEQ_TIMEOUT_EN` defined:
  - WAIT_BUSY counts cycles. If `BUSY_TIMEOUT` cycles pass without `ctrl_busy`, pulse `err` with code 10, then go to FINISH, which flushes the FIFO and pulses `done`.
- Undefined: WAIT_BUSY waits indefinitely and the counter is not synthesized.

## Structure
- Shared package `hram_pkg`:
  - State enum encoding.
  - `err_code` constants ERR_NONE/ERR_UNDERRUN/ERR_TIMEOUT.
  - Word width constant (32).
- One sub-module: `hram_wr_fifo`, a synchronous FWFT FIFO with count output and a flush input.

## Test plan
- **Memory write, 4 words:** push 0xA0..0xA3, then issue a write command to 0x100. Required:
  - `ctrl_cs` pulses once.
  - The four `ctrl_wr_data_next` pops present 0xA0..0xA3 in order.
  - `done` pulses once; FIFO empty afterwards.
- **Memory read, 3 words:** the controller model returns 0x11, 0x22, 0x33, 0x44. Required: `rd_valid` ×3 carrying 0x11, 0x22, 0x33, each 1 cycle after its source; 0x44 dropped.
- **Register write with `cmd_num_words` = 5:** required `ctrl_num_words` = 1 and `ctrl_reg_sel` = 1.
- **Zero-length command:** required `done` 1 cycle later with no `ctrl_cs`.
- **Write, 20 words, `FIFO_DEPTH` = 16, host stalls after 16 pushes:** required start on full, then an underrun `err` with code 01 and data 0 on the 17th pop.
- **Timeout (`HRAM_SEQ_TIMEOUT_EN`):** `ctrl_busy` held 0. Required `err` with code 10 exactly 32 cycles after `ctrl_cs`, then `done`. Separately, assert `rst_n` low mid-RUN: all outputs reach their reset values.
